moore_arb: RTL and testbench

MOORE_ARB -- requirements
Module: moore_arb

---
 rtl/moore_arb.sv | 192 +++++++++++++++++++
 tb/tb_moore_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/moore_arb.sv
// Round-robin arbiter that time-shares one Moore detector among four requesters.
// Optional per-requester hit counters are built when MOORE_ARB_STATS_EN is defined.
module moore_arb #(
    parameter int         MAX_HOLD = 8,
    parameter logic [1:0] IDLE_SYM = 2'b00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  last,
    input  logic [7:0]  sym,
    output logic [3:0]  grant,
    output logic [1:0]  ain,
    output logic        det_rst,
    input  logic        aout_in,
    output logic [3:0]  det_hit,
    output logic [31:0] hit_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        FLUSH1 = 2'd2,
        FLUSH2 = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    // Returns {found, index}; the requester closest to p (upward, mod 4) wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    state_t     state_r, state_s;
    logic [1:0] owner_r, owner_s;
    logic [1:0] ptr_r, ptr_s;
    logic [7:0] hold_r, hold_s;
    logic [3:0] grant_r;
    logic       det_rst_r;
    logic [2:0] pick_s;
    logic [1:0] sym_sel_s;
    logic       tenure_end_s;

    assign pick_s       = rr_pick(req, ptr_r);
    assign tenure_end_s = last[owner_r] | ~req[owner_r] | (hold_r == HOLD_LAST);

    // Owner's symbol slice.
    always_comb begin
        sym_sel_s = sym[1:0];
        case (owner_r)
            2'd0:    sym_sel_s = sym[1:0];
            2'd1:    sym_sel_s = sym[3:2];
            2'd2:    sym_sel_s = sym[5:4];
            2'd3:    sym_sel_s = sym[7:6];
            default: sym_sel_s = sym[1:0];
        endcase
    end

    // Next-state, owner, pointer and hold-counter logic.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        ptr_s   = ptr_r;
        hold_s  = hold_r;
        case (state_r)
            IDLE: begin
                if (pick_s[2]) begin
                    state_s = GRANT;
                    owner_s = pick_s[1:0];
                    hold_s  = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                hold_s = hold_r + 8'd1;
                if (tenure_end_s) begin
                    state_s = FLUSH1;
                    ptr_s   = owner_r + 2'd1;
                end else begin
                    state_s = GRANT;
                end
            end
            FLUSH1: begin
                state_s = FLUSH2;
            end
            FLUSH2: begin
                // Back-to-back tenures skip IDLE.
                if (pick_s[2]) begin
                    state_s = GRANT;
                    owner_s = pick_s[1:0];
                    hold_s  = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and arbitration registers; reset aborts any tenure without flushing.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            owner_r <= 2'd0;
            ptr_r   <= 2'd0;
            hold_r  <= 8'd0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            hold_r  <= hold_s;
        end
    end

    // Registered grant and detector reset, decoded from the next state so they align with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_r   <= 4'b0000;
            det_rst_r <= 1'b1;
        end else begin
            grant_r   <= (state_s == GRANT) ? onehot(owner_s) : 4'b0000;
            det_rst_r <= (state_s == FLUSH2);
        end
    end

    assign grant   = grant_r;
    assign det_rst = det_rst_r;

    // Detector input mux and output routing; FLUSH1 still catches the late aout.
    always_comb begin
        ain     = IDLE_SYM;
        det_hit = 4'b0000;
        case (state_r)
            GRANT: begin
                ain     = sym_sel_s;
                det_hit = onehot(owner_r) & {4{aout_in}};
            end
            FLUSH1: begin
                ain     = IDLE_SYM;
                det_hit = onehot(owner_r) & {4{aout_in}};
            end
            default: begin
                ain     = IDLE_SYM;
                det_hit = 4'b0000;
            end
        endcase
    end

`ifdef MOORE_ARB_STATS_EN
    logic [7:0] cnt_r [4];

    // Saturating per-requester hit counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (det_hit[i] && (cnt_r[i] != 8'hFF)) begin
                    cnt_r[i] <= cnt_r[i] + 8'h01;
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    assign hit_cnt = {cnt_r[3], cnt_r[2], cnt_r[1], cnt_r[0]};
`else
    assign hit_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_moore_arb.sv
// Directed self-checking bench for moore_arb (default MAX_HOLD=8, IDLE_SYM=2'b00).
module tb_moore_arb;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [7:0]  sym;
    logic [3:0]  grant;
    logic [1:0]  ain;
    logic        det_rst;
    logic        aout_in;
    logic [3:0]  det_hit;
    logic [31:0] hit_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    moore_arb #(.MAX_HOLD(8), .IDLE_SYM(2'b00)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .last    (last),
        .sym     (sym),
        .grant   (grant),
        .ain     (ain),
        .det_rst (det_rst),
        .aout_in (aout_in),
        .det_hit (det_hit),
        .hit_cnt (hit_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_g;
        reset   = 1'b1;
        req     = 4'b0000;
        last    = 4'b0000;
        sym     = 8'h00;
        aout_in = 1'b0;
        tick();
        tick();
        chk("rst_grant",   32'(grant),   32'h0);
        chk("rst_det_rst", 32'(det_rst), 32'h1);
        chk("rst_ain",     32'(ain),     32'h0);
        chk("rst_det_hit", 32'(det_hit), 32'h0);
        chk("rst_hit_cnt", hit_cnt,      32'h0);

        // Reset release: det_rst drops on the first edge.
        reset = 1'b0;
        tick();
        chk("rel_det_rst", 32'(det_rst), 32'h0);
        chk("idle_grant",  32'(grant),   32'h0);

        // Single requester 2, one-cycle latency, ain tracks sym[5:4].
        sym = 8'b00_10_00_00;
        req = 4'b0100;
        #1;
        chk("idle_no_grant", 32'(grant), 32'h0);
        tick();
        chk("g2_grant", 32'(grant), 32'h4);
        chk("g2_ain",   32'(ain),   32'h2);
        sym     = 8'b00_01_11_11;
        aout_in = 1'b1;
        #1;
        chk("g2_ain_track", 32'(ain),     32'h1);
        chk("g2_det_hit",   32'(det_hit), 32'h4);
        aout_in = 1'b0;
        req     = 4'b0000;
        tick();
        chk("f1_grant",   32'(grant),   32'h0);
        chk("f1_det_rst", 32'(det_rst), 32'h0);
        chk("f1_ain",     32'(ain),     32'h0);
        aout_in = 1'b1;
        #1;
        chk("f1_det_hit", 32'(det_hit), 32'h4);
        tick();
        chk("f2_det_rst", 32'(det_rst), 32'h1);
        chk("f2_grant",   32'(grant),   32'h0);
        chk("f2_det_hit", 32'(det_hit), 32'h0);
        aout_in = 1'b0;
        tick();
        chk("idle_det_rst", 32'(det_rst), 32'h0);

        // Owner 1 ends its tenure with last on the 3rd cycle (ptr is 3 here).
        req = 4'b0010;
        tick();
        chk("l1_c1", 32'(grant), 32'h2);
        tick();
        chk("l1_c2", 32'(grant), 32'h2);
        tick();
        chk("l1_c3", 32'(grant), 32'h2);
        last = 4'b0010;
        tick();
        chk("l1_f1_grant", 32'(grant), 32'h0);
        last    = 4'b0000;
        req     = 4'b0000;
        aout_in = 1'b1;
        #1;
        chk("l1_f1_det_hit", 32'(det_hit), 32'h2);
        aout_in = 1'b0;
        tick();
        chk("l1_f2_det_rst", 32'(det_rst), 32'h1);
        tick();

        // Fresh reset, then all four requesting: 8-cycle tenures in rotation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_g = 4'b0001 << (t % 4);
            for (int c = 0; c < 8; c++) begin
                tick();
                chk($sformatf("rr_t%0d_c%0d", t, c), 32'(grant), 32'(exp_g));
            end
            if (t == 4) begin
                req = 4'b1000;
            end
            tick();
            chk($sformatf("rr_gap1_t%0d", t), {28'h0, grant, 3'b0, det_rst}, 32'h0);
            tick();
            chk($sformatf("rr_gap2_t%0d", t), {28'h0, grant, 3'b0, det_rst}, 32'h1);
        end

        // Owner 3 directly from FLUSH2, then reset mid-tenure.
        tick();
        chk("o3_grant", 32'(grant), 32'h8);
        tick();
        aout_in = 1'b1;
        reset   = 1'b1;
        #1;
        chk("mid_rst_grant",   32'(grant),   32'h0);
        chk("mid_rst_det_rst", 32'(det_rst), 32'h1);
        chk("mid_rst_det_hit", 32'(det_hit), 32'h0);
        chk("mid_rst_ain",     32'(ain),     32'h0);
        aout_in = 1'b0;
        req     = 4'b1010;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_grant",   32'(grant),   32'h2);
        chk("post_rst_det_rst", 32'(det_rst), 32'h0);
        req = 4'b0000;
        tick();
        tick();
        tick();

`ifdef MOORE_ARB_STATS_EN
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        req     = 4'b0100;
        aout_in = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
        end
        chk("stats_sat", hit_cnt, 32'h00FF_0000);
        tick();
        tick();
        chk("stats_hold", hit_cnt, 32'h00FF_0000);
        req     = 4'b0000;
        aout_in = 1'b0;
`else
        chk("no_stats_hit_cnt", hit_cnt, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
